// File: rtl/cabac_ctx_ram_ctrl.sv
// CABAC context RF controller: slice-start init sweep, then read/write-back
// service with same-cycle write-to-read forwarding.
//
// Ports:
//   clk, rstn                 clock, async active-low reset
//   start_i                   pulse that (re)starts the init sweep
//   busy_o / done_o           init in progress / one pulse when init completes
//   init_idx_o, init_val_i    combinational init-table lookup
//   rd_req_i, rd_addr_i       context read request
//   rd_vld_o, rd_data_o       read response, one cycle later
//   wb_en_i, wb_addr_i,
//   wb_data_i                 context write-back
//   ram_r_*, ram_w_*          two-port register-file interface
module cabac_ctx_ram_ctrl #(
  parameter int CTX_W   = 7,
  parameter int ADDR_W  = 6,
  parameter int CTX_NUM = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] init_idx_o,
  input  logic [CTX_W-1:0]  init_val_i,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_vld_o,
  output logic [CTX_W-1:0]  rd_data_o,
  input  logic              wb_en_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [CTX_W-1:0]  wb_data_i,
  output logic              ram_r_en_o,
  output logic [ADDR_W-1:0] ram_r_addr_o,
  input  logic [CTX_W-1:0]  ram_r_data_i,
  output logic              ram_w_en_o,
  output logic [ADDR_W-1:0] ram_w_addr_o,
  output logic [CTX_W-1:0]  ram_w_data_o
);

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    READY
  } state_e;

  // One extra bit so CTX_NUM == 2**ADDR_W never wraps.
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(CTX_NUM - 1);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              vld_q, vld_d;
  logic              fwd_q, fwd_d;
  logic [CTX_W-1:0]  fwd_data_q, fwd_data_d;
  logic              rd_go;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      vld_q      <= 1'b0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      vld_q      <= vld_d;
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    done_d       = 1'b0;
    vld_d        = 1'b0;
    fwd_d        = 1'b0;
    fwd_data_d   = fwd_data_q;
    rd_go        = 1'b0;
    busy_o       = 1'b0;
    init_idx_o   = '0;
    ram_r_en_o   = 1'b0;
    ram_r_addr_o = '0;
    ram_w_en_o   = 1'b0;
    ram_w_addr_o = '0;
    ram_w_data_o = '0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      INIT: begin
        busy_o       = 1'b1;
        init_idx_o   = cnt_q[ADDR_W-1:0];
        ram_w_en_o   = 1'b1;
        ram_w_addr_o = cnt_q[ADDR_W-1:0];
        ram_w_data_o = init_val_i;
        if (start_i) begin
          cnt_d = '0;
        end else if (cnt_q == LAST) begin
          state_d = READY;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      READY: begin
        // A read arriving with start_i is dropped; the sweep will
        // overwrite the context it would have returned.
        rd_go        = rd_req_i & ~start_i;
        ram_r_en_o   = rd_go;
        ram_r_addr_o = rd_addr_i;
        ram_w_en_o   = wb_en_i;
        ram_w_addr_o = wb_addr_i;
        ram_w_data_o = wb_data_i;
        vld_d        = rd_go;
        // RF reads old data on a same-address write; bypass it.
        if (rd_go && wb_en_i && (rd_addr_i == wb_addr_i)) begin
          fwd_d      = 1'b1;
          fwd_data_d = wb_data_i;
        end
        if (start_i) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign done_o    = done_q;
  assign rd_vld_o  = vld_q;
  assign rd_data_o = fwd_q ? fwd_data_q : ram_r_data_i;

endmodule

// File: tb/tb_cabac_ctx_ram_ctrl.sv
// Self-checking bench for cabac_ctx_ram_ctrl: behavioural RF model,
// init-table model and a read-response scoreboard.
module tb_cabac_ctx_ram_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start_i;
  logic       busy_o, done_o;
  logic [5:0] init_idx_o;
  logic [6:0] init_val_i;
  logic       rd_req_i;
  logic [5:0] rd_addr_i;
  logic       rd_vld_o;
  logic [6:0] rd_data_o;
  logic       wb_en_i;
  logic [5:0] wb_addr_i;
  logic [6:0] wb_data_i;
  logic       ram_r_en_o;
  logic [5:0] ram_r_addr_o;
  logic [6:0] ram_r_data_i;
  logic       ram_w_en_o;
  logic [5:0] ram_w_addr_o;
  logic [6:0] ram_w_data_o;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  logic [6:0] exp_addr = '0;
  logic [6:0] ref_ctx [64];
  logic [6:0] sb_q [$];
  logic [6:0] mem [64];

  always #5 clk = ~clk;

  cabac_ctx_ram_ctrl dut (
    .clk          (clk),
    .rstn         (rstn),
    .start_i      (start_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .init_idx_o   (init_idx_o),
    .init_val_i   (init_val_i),
    .rd_req_i     (rd_req_i),
    .rd_addr_i    (rd_addr_i),
    .rd_vld_o     (rd_vld_o),
    .rd_data_o    (rd_data_o),
    .wb_en_i      (wb_en_i),
    .wb_addr_i    (wb_addr_i),
    .wb_data_i    (wb_data_i),
    .ram_r_en_o   (ram_r_en_o),
    .ram_r_addr_o (ram_r_addr_o),
    .ram_r_data_i (ram_r_data_i),
    .ram_w_en_o   (ram_w_en_o),
    .ram_w_addr_o (ram_w_addr_o),
    .ram_w_data_o (ram_w_data_o)
  );

  // Init table and two-port RF (read returns pre-write contents).
  assign init_val_i = {1'b0, init_idx_o} ^ 7'h2A;

  always @(posedge clk) begin
    if (ram_r_en_o) ram_r_data_i <= mem[ram_r_addr_o];
    if (ram_w_en_o) mem[ram_w_addr_o] <= ram_w_data_o;
  end

  // Monitor: read responses against scoreboard, init writes against sweep.
  always @(negedge clk) begin
    if (rstn) begin
      if (rd_vld_o) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL rd_vld_unexpected: got rd_vld_o=1 data=%h, want none",
                   rd_data_o);
        end else begin
          logic [6:0] e;
          e = sb_q.pop_front();
          if (rd_data_o !== e) begin
            errors++;
            $display("FAIL rd_data: got %h want %h", rd_data_o, e);
          end
        end
      end
      if (busy_o) begin
        checks++;
        if (ram_w_en_o !== 1'b1 || ram_w_addr_o !== exp_addr[5:0] ||
            ram_w_data_o !== (exp_addr ^ 7'h2A) || ram_r_en_o !== 1'b0) begin
          errors++;
          $display("FAIL init_write: got en=%b a=%0d d=%h ren=%b want 1 %0d %h 0",
                   ram_w_en_o, ram_w_addr_o, ram_w_data_o, ram_r_en_o,
                   exp_addr, exp_addr ^ 7'h2A);
        end
        wr_cnt++;
      end
      if (start_i) exp_addr = '0;
      else if (busy_o) exp_addr = exp_addr + 7'd1;
    end else begin
      exp_addr = '0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_ref();
    for (int i = 0; i < 64; i++) ref_ctx[i] = 7'(i) ^ 7'h2A;
  endtask

  task automatic issue(input logic rd, input logic [5:0] ra,
                       input logic wb, input logic [5:0] wa,
                       input logic [6:0] wd);
    rd_req_i  = rd;
    rd_addr_i = ra;
    wb_en_i   = wb;
    wb_addr_i = wa;
    wb_data_i = wd;
    if (rd) sb_q.push_back((wb && wa == ra) ? wd : ref_ctx[ra]);
    if (wb) ref_ctx[wa] = wd;
    #1;
    checks++;
    if (ram_r_en_o !== rd || ram_w_en_o !== wb) begin
      errors++;
      $display("FAIL ready_passthru: got ren=%b wen=%b want %b %b",
               ram_r_en_o, ram_w_en_o, rd, wb);
    end
    @(posedge clk);
    #1;
    rd_req_i = 1'b0;
    wb_en_i  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 5 && sb_q.size() != 0; i++) step();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending reads want 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic run_init(input string name);
    int n_busy, n_done, at;
    n_busy = 0; n_done = 0; at = 0;
    wr_cnt = 0;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (busy_o) n_busy++;
      if (done_o) begin n_done++; at = i; end
      step();
    end
    checks++;
    if (n_busy != 64 || n_done != 1 || at != 65 || wr_cnt != 64) begin
      errors++;
      $display("FAIL %s: got busy=%0d done=%0d@%0d writes=%0d want 64 1@65 64",
               name, n_busy, n_done, at, wr_cnt);
    end
    reset_ref();
  endtask

  task automatic test_reset();
    rstn = 1'b0; start_i = 1'b0; rd_req_i = 1'b0; rd_addr_i = '0;
    wb_en_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
    #12;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || rd_vld_o !== 1'b0 ||
        init_idx_o !== '0 || ram_r_en_o !== 1'b0 || ram_r_addr_o !== '0 ||
        ram_w_en_o !== 1'b0 || ram_w_addr_o !== '0 || ram_w_data_o !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b vld=%b ren=%b wen=%b want all 0",
               busy_o, done_o, rd_vld_o, ram_r_en_o, ram_w_en_o);
    end
    step();
    rstn = 1'b1;
    step();
  endtask

  task automatic test_init();
    run_init("init_sweep");
  endtask

  task automatic test_read();
    issue(1'b1, 6'd5, 1'b0, 6'd0, 7'h00);
    checks++;
    if (ref_ctx[5] !== 7'h2F || rd_vld_o !== 1'b1) begin
      errors++;
      $display("FAIL read5_vld: got vld=%b want 1", rd_vld_o);
    end
    drain();
  endtask

  task automatic test_forward();
    issue(1'b1, 6'd9, 1'b1, 6'd9, 7'h11);
    issue(1'b1, 6'd9, 1'b0, 6'd0, 7'h00);
    drain();
  endtask

  task automatic test_no_forward();
    issue(1'b1, 6'd9, 1'b1, 6'd10, 7'h55);
    step();
    issue(1'b1, 6'd10, 1'b0, 6'd0, 7'h00);
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      issue(1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
            7'($urandom));
    end
    drain();
  endtask

  task automatic test_start_ready();
    issue(1'b1, 6'd3, 1'b0, 6'd0, 7'h00);
    start_i = 1'b1; rd_req_i = 1'b1; rd_addr_i = 6'd4;
    #1;
    checks++;
    if (ram_r_en_o !== 1'b0 || rd_vld_o !== 1'b1) begin
      errors++;
      $display("FAIL start_in_ready: got ren=%b vld=%b want 0 1",
               ram_r_en_o, rd_vld_o);
    end
    step();
    start_i = 1'b0; rd_req_i = 1'b0;
    checks++;
    if (rd_vld_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL start_drop_read: got vld=%b busy=%b want 0 1",
               rd_vld_o, busy_o);
    end
    for (int i = 0; i < 70; i++) step();
    reset_ref();
    drain();
  endtask

  task automatic test_abort();
    int n_done, at;
    n_done = 0; at = 0;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 1; i < 30; i++) begin
      rd_req_i = 1'b1; rd_addr_i = 6'(i);
      wb_en_i = 1'b1; wb_addr_i = 6'(i); wb_data_i = 7'h7F;
      #1;
      checks++;
      if (ram_r_en_o !== 1'b0 || rd_vld_o !== 1'b0) begin
        errors++;
        $display("FAIL init_ignores_req: got ren=%b vld=%b want 0 0",
                 ram_r_en_o, rd_vld_o);
      end
      @(negedge clk);
      if (done_o) n_done++;
      step();
    end
    rd_req_i = 1'b0; wb_en_i = 1'b0;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    wr_cnt = 0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (done_o) begin n_done++; at = i; end
      step();
    end
    checks++;
    if (wr_cnt != 64 || n_done != 1 || at != 65) begin
      errors++;
      $display("FAIL abort_restart: got writes=%0d done=%0d@%0d want 64 1@65",
               wr_cnt, n_done, at);
    end
    reset_ref();
    issue(1'b1, 6'd7, 1'b0, 6'd0, 7'h00);
    drain();
  endtask

  task automatic test_reset_mid_init();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 1; i < 20; i++) step();
    rstn = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || rd_vld_o !== 1'b0 ||
        init_idx_o !== '0 || ram_w_en_o !== 1'b0 || ram_w_addr_o !== '0 ||
        ram_w_data_o !== '0 || ram_r_en_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_init: got busy=%b wen=%b idx=%0d want 0 0 0",
               busy_o, ram_w_en_o, init_idx_o);
    end
    step();
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd_req_i = 1'b1; rd_addr_i = 6'(i);
      @(negedge clk);
      checks++;
      if (rd_vld_o !== 1'b0 || ram_r_en_o !== 1'b0 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_reset: got vld=%b ren=%b busy=%b want 0 0 0",
                 rd_vld_o, ram_r_en_o, busy_o);
      end
      step();
    end
    rd_req_i = 1'b0;
    run_init("reinit_after_reset");
    issue(1'b1, 6'd20, 1'b0, 6'd0, 7'h00);
    drain();
  endtask

  initial begin
    test_reset();
    test_init();
    test_read();
    test_forward();
    test_no_forward();
    test_back_to_back();
    test_start_ready();
    test_abort();
    test_reset_mid_init();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
